lux_bcd_conv: RTL and testbench

Downstream stage of the BH1750 I2C controller. Captures the 16-bit raw illuminance word when the controller's done flag rises, scales it to lux (raw × 5 / 6, i.e. raw / 1.2, truncated), and converts the result to five packed BCD digits for the LCD1602 display writer. Conversion is fully sequential: a restoring divider followed by a double-dabble shifter. Fixed latency, no multipliers.

---
 rtl/bh1750_pkg.sv | 23 ++
 rtl/lux_bcd_conv_if.sv | 38 +++
 rtl/bin2bcd_dd.sv | 77 +++++++
 rtl/lux_bcd_conv.sv | 146 ++++++++++++++
 tb/tb_lux_bcd_conv.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/bh1750_pkg.sv
// Shared definitions for the BH1750 lux display path.
// Contents:
//   state_t  - conversion FSM states.
//   RAW_W, DIVIDEND_W, BCD_DIGITS, BCD_W - datapath widths.
//   DIV_ITER, BCD_ITER - cycles spent in the divide and BCD phases.
package bh1750_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCALE,
        DIV,
        BCD,
        DONE
    } state_t;

    localparam int RAW_W      = 16;
    localparam int DIVIDEND_W = 19;
    localparam int BCD_DIGITS = 5;
    localparam int BCD_W      = 20;
    localparam int DIV_ITER   = 19;
    localparam int BCD_ITER   = 16;

endpackage

// File: rtl/lux_bcd_conv_if.sv
// Bus between the BH1750 I2C controller, the lux/BCD converter and the LCD writer.
// Signals:
//   i_data      - raw 16-bit sensor count
//   i_tick_done - controller done level (about 1 s per measurement)
//   o_bcd       - five packed BCD digits, ten-thousands in [19:16]
//   o_digits    - significant digit count 1..5
//   o_valid     - one-cycle strobe when o_bcd/o_digits update
//   o_busy      - conversion in flight
// Modports: master = controller/consumer side, slave = converter.
interface lux_bcd_conv_if;
    import bh1750_pkg::*;

    logic [RAW_W-1:0] i_data;
    logic             i_tick_done;
    logic [BCD_W-1:0] o_bcd;
    logic [2:0]       o_digits;
    logic             o_valid;
    logic             o_busy;

    modport master (
        output i_data,
        output i_tick_done,
        input  o_bcd,
        input  o_digits,
        input  o_valid,
        input  o_busy
    );

    modport slave (
        input  i_data,
        input  i_tick_done,
        output o_bcd,
        output o_digits,
        output o_valid,
        output o_busy
    );

endinterface

// File: rtl/bin2bcd_dd.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble).
// Ports:
//   i_clk, i_rst - clock, synchronous active-high reset (control only)
//   i_start      - one-cycle pulse; i_bin is consumed on this cycle
//   i_bin        - binary value to convert
//   o_bcd        - packed BCD result, stable once o_done has pulsed
//   o_done       - one-cycle pulse the cycle after the last iteration
// The start cycle already performs the first add-3/shift step, so the whole
// conversion takes exactly BCD_ITER clock edges from the start pulse.
module bin2bcd_dd
    import bh1750_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [RAW_W-1:0] i_bin,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_done
);

    logic [BCD_W-1:0]       r_bcd;
    logic [RAW_W-1:0]       r_bin;
    logic [3:0]             r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [BCD_W+RAW_W-1:0] step_start;
    logic [BCD_W+RAW_W-1:0] step_run;

    // One iteration: bump every nibble >= 5 by 3, then shift the whole
    // BCD:binary pair left by one.
    function automatic logic [BCD_W+RAW_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                                       input logic [RAW_W-1:0] bin);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        return {adj, bin} << 1;
    endfunction

    assign step_start = dd_step({BCD_W{1'b0}}, i_bin);
    assign step_run   = dd_step(r_bcd, r_bin);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= 4'd0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= 4'(BCD_ITER - 1);
            end else if (r_busy) begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_start) begin
            {r_bcd, r_bin} <= step_start;
        end else if (r_busy) begin
            {r_bcd, r_bin} <= step_run;
        end
    end

    assign o_bcd  = r_bcd;
    assign o_done = r_done;

endmodule

// File: rtl/lux_bcd_conv.sv
// Raw BH1750 count -> lux -> packed BCD for the LCD1602 writer.
// Captures i_data on the rising edge of i_tick_done, computes
// floor(raw * P_MUL / P_DIV) with a shift-add scale and a restoring divider,
// then converts the quotient to BCD with bin2bcd_dd. Fixed latency: the
// result strobes 37 edges after the capture edge.
// Ports:
//   i_clk, i_rst - clock, synchronous active-high reset
//   bus (slave)  - i_data, i_tick_done in; o_bcd, o_digits, o_valid, o_busy out
// Parameters: P_MUL 1..7, P_DIV 1..7 with P_MUL <= P_DIV.
module lux_bcd_conv
    import bh1750_pkg::*;
#(
    parameter int P_MUL = 5,
    parameter int P_DIV = 6
) (
    input  logic           i_clk,
    input  logic           i_rst,
    lux_bcd_conv_if.slave  bus
);

    localparam logic [2:0] MUL3    = 3'(P_MUL);
    localparam logic [3:0] DIVISOR = 4'(P_DIV);

    state_t                r_state;
    state_t                state_d;
    logic                  r_prev;
    logic [4:0]            r_cnt;
    logic [RAW_W-1:0]      r_raw;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [3:0]            r_rem;
    logic [BCD_W-1:0]      r_bcd;
    logic [2:0]            r_digits;
    logic                  r_valid;
    logic                  start;
    logic                  cnt_zero;
    logic                  dd_start;
    logic                  dd_done;
    logic [BCD_W-1:0]      dd_bcd;
    logic [3:0]            rem_sh;
    logic                  q_bit;

    function automatic logic [DIVIDEND_W-1:0] scale_mul(input logic [RAW_W-1:0] raw);
        logic [DIVIDEND_W-1:0] base;
        logic [DIVIDEND_W-1:0] acc;
        base = DIVIDEND_W'(raw);
        acc  = '0;
        if (MUL3[0]) acc = acc + base;
        if (MUL3[1]) acc = acc + (base << 1);
        if (MUL3[2]) acc = acc + (base << 2);
        return acc;
    endfunction

    // Highest non-zero digit position wins; an all-zero value still shows one digit.
    function automatic logic [2:0] digit_count(input logic [BCD_W-1:0] bcd);
        logic [2:0] n;
        n = 3'd1;
        for (int i = 1; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) n = 3'(i + 1);
        end
        return n;
    endfunction

    assign start    = bus.i_tick_done & ~r_prev & (r_state == IDLE);
    assign cnt_zero = (r_cnt == 5'd0);
    assign dd_start = (r_state == BCD) && (r_cnt == 5'(BCD_ITER - 1));

    // Restoring step: the dividend MSB shifts into the remainder, and the
    // quotient bit shifts into the freed LSB of the dividend register, so
    // after DIV_ITER steps r_dvd holds the quotient.
    assign rem_sh = (r_rem << 1) | {3'b000, r_dvd[DIVIDEND_W-1]};
    assign q_bit  = (rem_sh >= DIVISOR);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= state_d;
    end

    always_comb begin
        state_d = r_state;
        case (r_state)
            IDLE:    if (start) state_d = SCALE;
            SCALE:   state_d = DIV;
            DIV:     if (cnt_zero) state_d = BCD;
            BCD:     if (cnt_zero) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev   <= 1'b0;
            r_cnt    <= 5'd0;
            r_bcd    <= '0;
            r_digits <= 3'd1;
            r_valid  <= 1'b0;
        end else begin
            r_prev  <= bus.i_tick_done;
            r_valid <= 1'b0;
            case (r_state)
                SCALE: r_cnt <= 5'(DIV_ITER - 1);
                DIV:   r_cnt <= cnt_zero ? 5'(BCD_ITER - 1) : r_cnt - 5'd1;
                BCD:   if (!cnt_zero) r_cnt <= r_cnt - 5'd1;
                DONE: begin
                    if (dd_done) begin
                        r_bcd    <= dd_bcd;
                        r_digits <= digit_count(dd_bcd);
                        r_valid  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        case (r_state)
            IDLE: if (start) r_raw <= bus.i_data;
            SCALE: begin
                r_dvd <= scale_mul(r_raw);
                r_rem <= 4'd0;
            end
            DIV: begin
                r_dvd <= {r_dvd[DIVIDEND_W-2:0], q_bit};
                r_rem <= q_bit ? rem_sh - DIVISOR : rem_sh;
            end
            default: ;
        endcase
    end

    bin2bcd_dd u_bin2bcd (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (dd_start),
        .i_bin   (r_dvd[RAW_W-1:0]),
        .o_bcd   (dd_bcd),
        .o_done  (dd_done)
    );

    // Busy also covers the strobe cycle so it spans capture to next-accept.
    assign bus.o_busy   = (r_state != IDLE) | r_valid;
    assign bus.o_bcd    = r_bcd;
    assign bus.o_digits = r_digits;
    assign bus.o_valid  = r_valid;

endmodule

// File: tb/tb_lux_bcd_conv.sv
// Directed bench for lux_bcd_conv: reset values, conversion table, retrigger
// rejection, held level, mid-conversion reset and a random sweep.
module tb_lux_bcd_conv;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    lux_bcd_conv_if bus ();

    lux_bcd_conv #(.P_MUL(5), .P_DIV(6)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] raws [8] = '{16'h0000, 16'd12, 16'd1000, 16'hFFFF,
                              16'd6, 16'd120, 16'd1200, 16'd12000};
    logic [19:0] exps [8] = '{20'h00000, 20'h00010, 20'h00833, 20'h54612,
                              20'h00005, 20'h00100, 20'h01000, 20'h10000};
    logic [2:0]  digs [8] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd3, 3'd4, 3'd5};

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Drop the done level, raise it with new data, and watch edges 0..44.
    task automatic do_conv(input logic [15:0] raw, output int lat, output int vcnt,
                           output int bcnt, output logic [19:0] bcd, output logic [2:0] dig);
        lat  = -1;
        vcnt = 0;
        bcnt = 0;
        bcd  = '0;
        dig  = '0;
        @(negedge clk);
        bus.i_tick_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.i_data      = raw;
        bus.i_tick_done = 1'b1;
        for (int e = 0; e < 45; e++) begin
            @(posedge clk);
            #1;
            if (bus.o_busy) bcnt++;
            if (bus.o_valid) begin
                vcnt++;
                if (lat < 0) begin
                    lat = e;
                    bcd = bus.o_bcd;
                    dig = bus.o_digits;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_data = '0;
        bus.i_tick_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.o_bcd !== 20'h0) begin bad++; $display("FAIL reset_bcd: got %h want 00000", bus.o_bcd); end
        total++; if (bus.o_digits !== 3'd1) begin bad++; $display("FAIL reset_digits: got %0d want 1", bus.o_digits); end
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_conversions();
        int lat, vcnt, bcnt;
        logic [19:0] bcd;
        logic [2:0] dig;
        for (int i = 0; i < 8; i++) begin
            do_conv(raws[i], lat, vcnt, bcnt, bcd, dig);
            total++; if (lat != 37) begin bad++; $display("FAIL conv_latency raw=%0d: got %0d want 37", raws[i], lat); end
            total++; if (vcnt != 1) begin bad++; $display("FAIL conv_valid_width raw=%0d: got %0d want 1", raws[i], vcnt); end
            total++; if (bcnt != 38) begin bad++; $display("FAIL conv_busy_cycles raw=%0d: got %0d want 38", raws[i], bcnt); end
            total++; if (bcd !== exps[i]) begin bad++; $display("FAIL conv_bcd raw=%0d: got %h want %h", raws[i], bcd, exps[i]); end
            total++; if (dig !== digs[i]) begin bad++; $display("FAIL conv_digits raw=%0d: got %0d want %0d", raws[i], dig, digs[i]); end
            total++; if (bus.o_bcd !== exps[i]) begin bad++; $display("FAIL conv_hold raw=%0d: got %h want %h", raws[i], bus.o_bcd, exps[i]); end
        end
    endtask

    task automatic test_retrigger();
        int lat, vcnt;
        logic [19:0] bcd;
        lat  = -1;
        vcnt = 0;
        bcd  = '0;
        @(negedge clk);
        bus.i_tick_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.i_data      = 16'd100;
        bus.i_tick_done = 1'b1;
        for (int e = 0; e < 80; e++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) begin
                vcnt++;
                if (lat < 0) begin
                    lat = e;
                    bcd = bus.o_bcd;
                end
            end
            if (e == 9) begin
                @(negedge clk);
                bus.i_tick_done = 1'b0;
                bus.i_data      = 16'd5000;
            end
            if (e == 10) begin
                @(negedge clk);
                bus.i_tick_done = 1'b1;
            end
        end
        total++; if (vcnt != 1) begin bad++; $display("FAIL retrig_valid_count: got %0d want 1", vcnt); end
        total++; if (lat != 37) begin bad++; $display("FAIL retrig_latency: got %0d want 37", lat); end
        total++; if (bcd !== 20'h00083) begin bad++; $display("FAIL retrig_bcd: got %h want 00083", bcd); end
    endtask

    task automatic test_hold();
        int vcnt;
        vcnt = 0;
        @(negedge clk);
        bus.i_tick_done = 1'b1;
        bus.i_data      = 16'd777;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) vcnt++;
        end
        total++; if (vcnt != 0) begin bad++; $display("FAIL hold_no_retrigger: got %0d strobes want 0", vcnt); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [19:0] bcd;
        lat = -1;
        bcd = '0;
        @(negedge clk);
        bus.i_tick_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.i_data      = 16'd1000;
        bus.i_tick_done = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.o_bcd !== 20'h0) begin bad++; $display("FAIL midrst_bcd: got %h want 00000", bus.o_bcd); end
        total++; if (bus.o_digits !== 3'd1) begin bad++; $display("FAIL midrst_digits: got %0d want 1", bus.o_digits); end
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bus.o_valid); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.o_busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 45; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) begin
                total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL midrst_restart_busy: got %b want 1", bus.o_busy); end
            end
            if (bus.o_valid && lat < 0) begin
                lat = e;
                bcd = bus.o_bcd;
            end
        end
        total++; if (lat != 37) begin bad++; $display("FAIL midrst_latency: got %0d want 37", lat); end
        total++; if (bcd !== 20'h00833) begin bad++; $display("FAIL midrst_bcd_after: got %h want 00833", bcd); end
    endtask

    task automatic test_sweep();
        int lat, vcnt, bcnt;
        logic [19:0] bcd;
        logic [2:0] dig;
        logic [15:0] raw;
        logic [19:0] exp_bcd;
        for (int n = 0; n < 1000; n++) begin
            raw     = 16'($urandom);
            exp_bcd = to_bcd((int'(raw) * 5) / 6);
            do_conv(raw, lat, vcnt, bcnt, bcd, dig);
            total++;
            if (bcd !== exp_bcd || lat != 37) begin
                bad++;
                $display("FAIL sweep raw=%0d: got %h lat %0d want %h lat 37", raw, bcd, lat, exp_bcd);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.i_data = '0;
        bus.i_tick_done = 1'b0;
        test_reset();
        test_conversions();
        test_retrigger();
        test_hold();
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
